// File: rtl/position_uart_tx.sv
// Position frame UART transmitter.
// Sends a 6-byte frame (sync, position MSB..LSB, XOR checksum) as 8N1 serial data.
module position_uart_tx #(
    parameter int unsigned BAUD_DIV  = 10417,
    parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] position,
    output logic        tx,
    output logic        busy,
    output logic        done
);

    localparam int unsigned BAUD_W    = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam int unsigned LAST_BYTE = 5;

    typedef enum logic [1:0] {
        IDLE,
        START_BIT,
        DATA,
        STOP_BIT
    } state_e;

    state_e              state_q,    state_d;
    logic [BAUD_W-1:0]   baud_cnt_q, baud_cnt_d;
    logic [2:0]          bit_cnt_q,  bit_cnt_d;
    logic [2:0]          byte_idx_q, byte_idx_d;
    logic [7:0]          shift_q,    shift_d;
    logic [31:0]         pos_q,      pos_d;
    logic                tx_q,       tx_d;
    logic                busy_q,     busy_d;
    logic                done_q,     done_d;
    logic                baud_last;

    // Byte idx of the frame, built from the latched position
    function automatic logic [7:0] frame_byte(input logic [2:0] idx, input logic [31:0] pos);
        logic [7:0] b;
        case (idx)
            3'd0:    b = SYNC_BYTE;
            3'd1:    b = pos[31:24];
            3'd2:    b = pos[23:16];
            3'd3:    b = pos[15:8];
            3'd4:    b = pos[7:0];
            3'd5:    b = pos[31:24] ^ pos[23:16] ^ pos[15:8] ^ pos[7:0];
            default: b = 8'hFF;
        endcase
        return b;
    endfunction

    assign baud_last = (baud_cnt_q == BAUD_W'(BAUD_DIV - 1));

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            baud_cnt_q <= '0;
            bit_cnt_q  <= '0;
            byte_idx_q <= '0;
            shift_q    <= '0;
            pos_q      <= '0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            baud_cnt_q <= baud_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            byte_idx_q <= byte_idx_d;
            shift_q    <= shift_d;
            pos_q      <= pos_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    // Next-state and registered-output logic; tx_d is the line level of the next cycle
    always_comb begin
        state_d    = state_q;
        baud_cnt_d = baud_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        byte_idx_d = byte_idx_q;
        shift_d    = shift_q;
        pos_d      = pos_q;
        tx_d       = tx_q;
        busy_d     = busy_q;
        done_d     = 1'b0;

        case (state_q)
            IDLE: begin
                tx_d   = 1'b1;
                busy_d = 1'b0;
                if (start) begin
                    state_d    = START_BIT;
                    pos_d      = position;
                    shift_d    = SYNC_BYTE;
                    baud_cnt_d = '0;
                    bit_cnt_d  = '0;
                    byte_idx_d = '0;
                    tx_d       = 1'b0;
                    busy_d     = 1'b1;
                end
            end

            START_BIT: begin
                if (baud_last) begin
                    state_d    = DATA;
                    baud_cnt_d = '0;
                    bit_cnt_d  = '0;
                    tx_d       = shift_q[0];
                end else begin
                    baud_cnt_d = baud_cnt_q + BAUD_W'(1);
                end
            end

            DATA: begin
                if (baud_last) begin
                    baud_cnt_d = '0;
                    if (bit_cnt_q == 3'd7) begin
                        state_d   = STOP_BIT;
                        bit_cnt_d = '0;
                        tx_d      = 1'b1;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        shift_d   = shift_q >> 1;
                        tx_d      = shift_q[1];
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q + BAUD_W'(1);
                end
            end

            STOP_BIT: begin
                if (baud_last) begin
                    baud_cnt_d = '0;
                    if (byte_idx_q == 3'(LAST_BYTE)) begin
                        state_d    = IDLE;
                        byte_idx_d = '0;
                        tx_d       = 1'b1;
                        busy_d     = 1'b0;
                        done_d     = 1'b1;
                    end else begin
                        state_d    = START_BIT;
                        byte_idx_d = byte_idx_q + 3'd1;
                        shift_d    = frame_byte(byte_idx_q + 3'd1, pos_q);
                        tx_d       = 1'b0;
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q + BAUD_W'(1);
                end
            end

            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    assign tx   = tx_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_position_uart_tx.sv
// Bench for position_uart_tx at 4 clk cycles per bit, scoreboard of expected frame bytes.
module tb_position_uart_tx;

    localparam int unsigned BAUD  = 4;
    localparam int          FRAME = 60 * BAUD;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] position;
    logic        tx;
    logic        busy;
    logic        done;

    logic [7:0]  exp_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;

    position_uart_tx #(
        .BAUD_DIV  (BAUD),
        .SYNC_BYTE (8'hA5)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .position (position),
        .tx       (tx),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected bytes for one frame carrying pos
    task automatic push_frame(input logic [31:0] pos);
        exp_q.push_back(8'hA5);
        exp_q.push_back(pos[31:24]);
        exp_q.push_back(pos[23:16]);
        exp_q.push_back(pos[15:8]);
        exp_q.push_back(pos[7:0]);
        exp_q.push_back(pos[31:24] ^ pos[23:16] ^ pos[15:8] ^ pos[7:0]);
    endtask

    // Pulse start for one cycle; returns #1 after the accepting edge (first start-bit cycle)
    task automatic start_frame(input logic [31:0] pos);
        push_frame(pos);
        position = pos;
        start    = 1'b1;
        @(posedge clk); #1;
        start    = 1'b0;
    endtask

    task automatic idle_check(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            check("idle_tx",   32'(tx),   32'd1);
            check("idle_busy", 32'(busy), 32'd0);
            check("idle_done", 32'(done), 32'd0);
        end
    endtask

    // Check one frame cycle by cycle; negative indices disable the optional actions
    task automatic run_frame(input int inject_at, input int chg_at, input int rst_at);
        logic [7:0] cur;
        logic       exp_tx;
        int         b;
        int         ph;
        cur = 8'h00;
        for (int k = 0; k < FRAME; k++) begin
            b  = (k / BAUD) % 10;
            ph = k % BAUD;
            if (b == 0 && ph == 0) begin
                check("sb_nonempty", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) cur = exp_q.pop_front();
            end
            exp_tx = (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : cur[3'(b - 1)];
            if (tx !== exp_tx)
                $error("FAIL frame_tx: cycle %0d byte %0h bit %0d observed %b expected %b",
                       k, cur, b, tx, exp_tx);
            n_checks++;
            assert (tx === exp_tx) else n_fail++;
            check("frame_busy", 32'(busy), 32'd1);
            check("frame_done", 32'(done), 32'd0);
            if (k == rst_at) begin
                rst = 1'b1;
                @(posedge clk); #1;
                rst = 1'b0;
                check("abort_tx",   32'(tx),   32'd1);
                check("abort_busy", 32'(busy), 32'd0);
                check("abort_done", 32'(done), 32'd0);
                exp_q.delete();
                return;
            end
            if (k == inject_at) begin
                start    = 1'b1;
                position = 32'hCAFEF00D;
            end else begin
                start = 1'b0;
            end
            if (k == chg_at) position = 32'hFFFFFFFF;
            @(posedge clk); #1;
        end
        start = 1'b0;
        check("end_done",   32'(done), 32'd1);
        check("end_busy",   32'(busy), 32'd0);
        check("end_tx",     32'(tx),   32'd1);
        check("sb_drained", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        position = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_tx",   32'(tx),   32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        rst = 1'b0;
        idle_check(2);

        // Basic frame: A5 12 34 56 78 08
        start_frame(32'h12345678);
        run_frame(-1, -1, -1);
        idle_check(3);

        // Position changed one cycle after start must not affect the frame
        start_frame(32'h12345678);
        run_frame(-1, 0, -1);
        idle_check(2);

        // Start while busy is ignored, no second frame follows
        start_frame(32'h12345678);
        run_frame(50, -1, -1);
        idle_check(8);

        // Back-to-back: start during the done cycle
        start_frame(32'h12345678);
        run_frame(-1, -1, -1);
        start_frame(32'h00000001);
        run_frame(-1, -1, -1);
        idle_check(2);

        // Reset mid-frame, then an all-zero frame
        start_frame(32'h12345678);
        run_frame(-1, -1, 100);
        idle_check(4 * FRAME / 60 + 4);
        start_frame(32'h00000000);
        run_frame(-1, -1, -1);
        idle_check(2);

        // Simultaneous rst and start: no transmission
        rst      = 1'b1;
        start    = 1'b1;
        position = 32'hDEADBEEF;
        @(posedge clk); #1;
        rst   = 1'b0;
        start = 1'b0;
        check("rs_tx",   32'(tx),   32'd1);
        check("rs_busy", 32'(busy), 32'd0);
        check("rs_done", 32'(done), 32'd0);
        idle_check(10);

        // First start after reset release is accepted
        start_frame(32'hDEADBEEF);
        run_frame(-1, -1, -1);
        idle_check(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
